// File: rtl/mx4_scan_pkg.sv
// Shared definitions for the mx4 scan controller: FSM encodings and dwell bounds.
package mx4_scan_pkg;

  localparam int unsigned DWELL_MIN = 1;
  localparam int unsigned DWELL_MAX = 16;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mx4.sv
// Plain 4:1 multiplexer: y follows d[s] combinationally.
module mx4
  import mx4_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] d,
  input  logic [SEL_W-1:0]  s,
  output logic              y
);

  assign y = d[s];

endmodule

// File: rtl/mx4_scan_ctrl.sv
// Steps a 4:1 mux through all channels, dwelling DWELL cycles on each, and captures one sample per channel.
// Optional parity output on the captured word is enabled with MX4_SCAN_PARITY_EN.
module mx4_scan_ctrl
  import mx4_scan_pkg::*;
#(
  parameter int unsigned DWELL = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] d,
  output logic [SEL_W-1:0]  s,
  output logic              y,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] q
`ifdef MX4_SCAN_PARITY_EN
  ,
  output logic              parity
`endif
);

  // Out-of-range DWELL values are clamped into the supported window.
  localparam int unsigned DWELL_EFF = (DWELL < DWELL_MIN) ? DWELL_MIN :
                                      (DWELL > DWELL_MAX) ? DWELL_MAX : DWELL;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_EFF - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [SEL_W-1:0]    s_nxt;
  logic [NUM_CH-1:0]   shadow;
  logic [NUM_CH-1:0]   shadow_nxt;
  logic [NUM_CH-1:0]   q_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  mx4 u_mx4 (
    .d (d),
    .s (s),
    .y (y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      cnt    <= '0;
      shadow <= '0;
      q      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef MX4_SCAN_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      s      <= s_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      q      <= q_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
`ifdef MX4_SCAN_PARITY_EN
      parity <= ^q_nxt;
`endif
    end
  end

  // Next-state and registered-output values; start is only honoured in IDLE.
  always_comb begin
    state_nxt  = state;
    s_nxt      = s;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    q_nxt      = q;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SCAN;
          s_nxt      = '0;
          cnt_nxt    = '0;
          shadow_nxt = '0;
          busy_nxt   = 1'b1;
        end
      end
      SCAN: begin
        busy_nxt = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_nxt       = '0;
          shadow_nxt[s] = y;
          if (s == SEL_W'(NUM_CH - 1)) begin
            // Last channel goes straight into q since shadow is not yet updated.
            state_nxt = DONE;
            q_nxt     = {y, shadow[NUM_CH-2:0]};
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            s_nxt = s + SEL_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
